// File: rtl/mdu_pkg.sv
// Shared op codes, FSM states and op-class helpers for the multiply/divide unit.
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } mdu_state_e;

    function automatic logic op_is_mul(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Restoring divider on unsigned magnitudes: one quotient bit per step, WIDTH steps per divide.
module mdu_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);

    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   trial;

    // quo doubles as the dividend shift register; its MSB feeds the partial remainder
    assign trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};

    always_ff @(posedge clk) begin
        if (load) begin
            rem <= '0;
            quo <= dividend;
            dvs <= divisor;
        end else if (step) begin
            if (!trial[WIDTH]) begin
                rem <= trial[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
                rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
                quo <= {quo[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Multiply is a registered product timed by a valid shift; divide runs on the iterative divider.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_MAX = (WIDTH > MULT_CYCLES) ? WIDTH : MULT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    mdu_state_e             state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [MULT_CYCLES-1:0] mvld;

    logic mul_go, div_load, div_step, wr_mul, wr_div, mt_hi, mt_lo;
    logic div_sgn, a_neg, b_neg;

    logic [2*WIDTH-1:0] prod_p0;
    logic [WIDTH-1:0]   a_p0;
    logic               qneg_p0, rneg_p0, bzero_p0;
    logic [WIDTH-1:0]   div_quo, div_rem;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + ONE) : v;
    endfunction

    // Operands are extended to 2*WIDTH, so the low half of the product is exact for both forms
    function automatic logic [2*WIDTH-1:0] mul_product(input logic [WIDTH-1:0] a,
                                                       input logic [WIDTH-1:0] b,
                                                       input logic sgn);
        logic signed [2*WIDTH-1:0] ae, be, p;
        ae = {{WIDTH{sgn & a[WIDTH-1]}}, a};
        be = {{WIDTH{sgn & b[WIDTH-1]}}, b};
        p  = ae * be;
        return p;
    endfunction

    function automatic logic [2*WIDTH-1:0] div_result(input logic [WIDTH-1:0] q,
                                                      input logic [WIDTH-1:0] r,
                                                      input logic [WIDTH-1:0] a_raw,
                                                      input logic qneg,
                                                      input logic rneg,
                                                      input logic bzero);
        if (bzero)
            return {a_raw, {WIDTH{1'b1}}};
        return {mag(r, rneg), mag(q, qneg)};
    endfunction

    assign div_sgn = (op == OP_DIV);
    assign a_neg   = div_sgn & src_a[WIDTH-1];
    assign b_neg   = div_sgn & src_b[WIDTH-1];
    assign busy    = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done      = 1'b0;
        mul_go    = 1'b0;
        div_load  = 1'b0;
        div_step  = 1'b0;
        wr_mul    = 1'b0;
        wr_div    = 1'b0;
        mt_hi     = 1'b0;
        mt_lo     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (op_is_mul(op)) begin
                        state_nxt = S_MUL;
                        cnt_nxt   = CNT_W'(MULT_CYCLES - 1);
                        mul_go    = 1'b1;
                    end else if (op_is_div(op)) begin
                        state_nxt = S_DIV;
                        cnt_nxt   = CNT_W'(WIDTH - 1);
                        div_load  = 1'b1;
                    end else if (op == OP_MTHI) begin
                        mt_hi = 1'b1;
                    end else if (op == OP_MTLO) begin
                        mt_lo = 1'b1;
                    end
                end
            end
            S_MUL: begin
                cnt_nxt = cnt - CNT_ONE;
                if (mvld[MULT_CYCLES-1]) begin
                    done      = 1'b1;
                    wr_mul    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end
            end
            S_DIV: begin
                div_step = 1'b1;
                cnt_nxt  = cnt - CNT_ONE;
                if (cnt == '0) begin
                    cnt_nxt   = '0;
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                done      = 1'b1;
                wr_div    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            mvld  <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            mvld[0] <= mul_go;
            for (int i = 1; i < MULT_CYCLES; i++)
                mvld[i] <= mvld[i-1];
        end
    end

    // ---- p0: operands captured on issue ----
    always_ff @(posedge clk) begin
        if (mul_go)
            prod_p0 <= mul_product(src_a, src_b, op == OP_MULT);
        if (div_load) begin
            a_p0      <= src_a;
            qneg_p0   <= a_neg ^ b_neg;
            rneg_p0   <= a_neg;
            bzero_p0  <= (src_b == '0);
        end
    end

    mdu_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .load     (div_load),
        .step     (div_step),
        .dividend (mag(src_a, a_neg)),
        .divisor  (mag(src_b, b_neg)),
        .quo      (div_quo),
        .rem      (div_rem)
    );

    // ---- HI/LO architectural state ----
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (wr_mul) begin
            {hi, lo} <= prod_p0;
        end else if (wr_div) begin
            {hi, lo} <= div_result(div_quo, div_rem, a_p0, qneg_p0, rneg_p0, bzero_p0);
        end else if (mt_hi) begin
            hi <= src_a;
        end else if (mt_lo) begin
            lo <= src_a;
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: a 32-bit and a 16-bit instance against a latency/arithmetic model.
module tb_mdu_seq;
    import mdu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start0, start1;
    logic [2:0]  op0, op1;
    logic [31:0] a0, b0;
    logic [15:0] a1, b1;
    logic        busy0, done0, busy1, done1;
    logic [31:0] hi0, lo0;
    logic [15:0] hi1, lo1;

    mdu_seq #(.WIDTH(32), .MULT_CYCLES(5)) dut0 (
        .clk(clk), .reset(rst), .start(start0), .op(op0), .src_a(a0), .src_b(b0),
        .busy(busy0), .done(done0), .hi(hi0), .lo(lo0));

    mdu_seq #(.WIDTH(16), .MULT_CYCLES(3)) dut1 (
        .clk(clk), .reset(rst), .start(start1), .op(op1), .src_a(a1), .src_b(b1),
        .busy(busy1), .done(done1), .hi(hi1), .lo(lo1));

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    logic [31:0] m_hi[2];
    logic [31:0] m_lo[2];
    logic [63:0] m_pend[2];
    int          m_rem[2] = '{0, 0};
    int          mc[2]    = '{5, 3};
    int          wd[2]    = '{32, 16};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference arithmetic for a w-bit unit; returns {hi, lo} in 32-bit halves
    function automatic logic [63:0] ref_res(input int w, input logic [2:0] o,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mask, am, bm, up, hv, lv;
        longint      sa, sb, p;
        mask = (64'd1 << w) - 64'd1;
        am   = {32'b0, a} & mask;
        bm   = {32'b0, b} & mask;
        sa   = am[w-1] ? longint'(am) - (longint'(1) << w) : longint'(am);
        sb   = bm[w-1] ? longint'(bm) - (longint'(1) << w) : longint'(bm);
        hv   = '0;
        lv   = '0;
        case (o)
            OP_MULT:  begin p = sa * sb; hv = 64'(p >>> w); lv = 64'(p); end
            OP_MULTU: begin up = am * bm; hv = up >> w; lv = up; end
            OP_DIV, OP_DIVU: begin
                if (bm == 0) begin
                    hv = am; lv = mask;
                end else if (o == OP_DIV) begin
                    hv = 64'(sa % sb); lv = 64'(sa / sb);
                end else begin
                    hv = am % bm; lv = am / bm;
                end
            end
            default: ;
        endcase
        return {hv[31:0] & mask[31:0], lv[31:0] & mask[31:0]};
    endfunction

    task automatic mstep(input int k, input logic s, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] b);
        if (rst) begin
            m_hi[k] = '0; m_lo[k] = '0; m_rem[k] = 0;
        end else if (m_rem[k] > 0) begin
            m_rem[k]--;
            if (m_rem[k] == 0) begin
                m_hi[k] = m_pend[k][63:32];
                m_lo[k] = m_pend[k][31:0];
            end
        end else if (s) begin
            case (o)
                OP_MULT, OP_MULTU: begin m_pend[k] = ref_res(wd[k], o, a, b); m_rem[k] = mc[k]; end
                OP_DIV, OP_DIVU:   begin m_pend[k] = ref_res(wd[k], o, a, b); m_rem[k] = wd[k] + 1; end
                OP_MTHI: m_hi[k] = a;
                OP_MTLO: m_lo[k] = a;
                default: ;
            endcase
        end
    endtask

    always @(posedge clk) begin
        mstep(0, start0, op0, a0, b0);
        mstep(1, start1, op1, {16'b0, a1}, {16'b0, b1});
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy0", 64'(busy0), 64'(m_rem[0] > 0));
            chk("done0", 64'(done0), 64'(m_rem[0] == 1));
            chk("hi0", {32'b0, hi0}, {32'b0, m_hi[0]});
            chk("lo0", {32'b0, lo0}, {32'b0, m_lo[0]});
            chk("busy1", 64'(busy1), 64'(m_rem[1] > 0));
            chk("done1", 64'(done1), 64'(m_rem[1] == 1));
            chk("hi1", {48'b0, hi1}, {48'b0, m_hi[1][15:0]});
            chk("lo1", {48'b0, lo1}, {48'b0, m_lo[1][15:0]});
        end
    end

    function automatic logic dbusy(input int k);
        return (k == 0) ? busy0 : busy1;
    endfunction

    function automatic logic ddone(input int k);
        return (k == 0) ? done0 : done1;
    endfunction

    function automatic logic [63:0] dres(input int k);
        return (k == 0) ? {hi0, lo0} : {16'b0, hi1, 16'b0, lo1};
    endfunction

    task automatic drive(input int k, input logic s, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] b);
        if (k == 0) begin
            start0 = s; op0 = o; a0 = a; b0 = b;
        end else begin
            start1 = s; op1 = o; a1 = a[15:0]; b1 = b[15:0];
        end
    endtask

    // Waits (bounded) for done, counting busy cycles; returns #1 after the result edge
    task automatic waitdone(input int k, output int bcyc);
        bit seen;
        seen = 1'b0;
        bcyc = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (dbusy(k)) bcyc++;
            if (ddone(k)) seen = 1'b1;
        end
        chk("done_seen", 64'(seen), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int k, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, output int bcyc);
        drive(k, 1'b1, o, a, b);
        @(posedge clk);
        #1;
        drive(k, 1'b0, o, $urandom, $urandom);
        waitdone(k, bcyc);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_8000;
            4: return 32'h1;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int bc;
        rst = 1'b1;
        drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 3'd0, 32'd0, 32'd0);
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_busy0", 64'(busy0), 64'd0);
        chk("rst_done0", 64'(done0), 64'd0);
        chk("rst_hilo0", {hi0, lo0}, 64'd0);
        rst = 1'b0;

        chk("ref_multu", ref_res(32, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        chk("ref_mult", ref_res(32, OP_MULT, -32'sd3, 32'd7), 64'hFFFF_FFFF_FFFF_FFEB);
        chk("ref_div", ref_res(32, OP_DIV, -32'sd7, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("ref_divu", ref_res(32, OP_DIVU, 32'd100, 32'd7), 64'h0000_0002_0000_000E);
        chk("ref_div0", ref_res(32, OP_DIVU, 32'd5, 32'd0), 64'h0000_0005_FFFF_FFFF);
        chk("ref_divmin16", ref_res(16, OP_DIV, 32'h8000, 32'hFFFF), 64'h0000_0000_0000_8000);

        run(0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc);
        chk("multu_res", dres(0), 64'hFFFF_FFFE_0000_0001);
        chk("multu_lat", 64'(bc), 64'd5);
        run(0, OP_MULT, -32'sd3, 32'd7, bc);
        chk("mult_res", dres(0), 64'hFFFF_FFFF_FFFF_FFEB);
        chk("mult_busy", 64'(bc), 64'd5);
        run(0, OP_DIV, -32'sd7, 32'd2, bc);
        chk("div_res", dres(0), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("div_lat", 64'(bc), 64'd33);
        run(0, OP_DIVU, 32'd100, 32'd7, bc);
        chk("divu_b2b_res", dres(0), 64'h0000_0002_0000_000E);
        chk("divu_b2b_lat", 64'(bc), 64'd33);
        run(0, OP_DIVU, 32'd5, 32'd0, bc);
        chk("div0_res", dres(0), 64'h0000_0005_FFFF_FFFF);
        chk("div0_lat", 64'(bc), 64'd33);
        run(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, bc);
        chk("divmin_res", dres(0), 64'h0000_0000_8000_0000);

        // MTLO and a second divide issued while a multiply is in flight must be dropped
        drive(0, 1'b1, OP_MULT, 32'd2, 32'd3);
        @(posedge clk); #1;
        drive(0, 1'b1, OP_MTLO, 32'h55, 32'd0);
        @(posedge clk); #1;
        drive(0, 1'b1, OP_DIVU, 32'd9, 32'd3);
        @(posedge clk); #1;
        drive(0, 1'b0, OP_MULT, 32'd0, 32'd0);
        waitdone(0, bc);
        chk("mtlo_busy_drop", dres(0), 64'h0000_0000_0000_0006);
        chk("busy_after_drop", 64'(busy0), 64'd0);

        drive(0, 1'b1, OP_MTHI, 32'hA5A5_0001, 32'd0);
        @(posedge clk); #1;
        drive(0, 1'b1, 3'b110, 32'd1, 32'd1);
        chk("mthi_res", {32'b0, hi0}, 64'h0000_0000_A5A5_0001);
        @(posedge clk); #1;
        drive(0, 1'b0, 3'b110, 32'd0, 32'd0);
        chk("undef_op_busy", 64'(busy0), 64'd0);

        run(1, OP_DIV, 32'hFFF9, 32'd2, bc);
        chk("div16_res", dres(1), 64'h0000_FFFF_0000_FFFD);
        chk("div16_lat", 64'(bc), 64'd17);
        run(1, OP_DIVU, 32'd100, 32'd7, bc);
        chk("divu16_res", dres(1), 64'h0000_0002_0000_000E);
        run(1, OP_DIVU, 32'd5, 32'd0, bc);
        chk("div0_16_res", dres(1), 64'h0000_0005_0000_FFFF);
        run(1, OP_DIV, 32'h8000, 32'hFFFF, bc);
        chk("divmin16_res", dres(1), 64'h0000_0000_0000_8000);
        run(1, OP_MULT, 32'hFFFD, 32'd7, bc);
        chk("mult16_res", dres(1), 64'h0000_FFFF_0000_FFEB);
        chk("mult16_lat", 64'(bc), 64'd3);

        // Reset in the middle of a divide: no result, no done, HI/LO cleared
        drive(0, 1'b1, OP_DIV, 32'd100, 32'd3);
        @(posedge clk); #1;
        drive(0, 1'b0, OP_DIV, 32'd0, 32'd0);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_busy", 64'(busy0), 64'd0);
        chk("rst_mid_done", 64'(done0), 64'd0);
        chk("rst_mid_hilo", dres(0), 64'd0);
        repeat (40) @(posedge clk);
        #1;

        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 3) == 0)
                    drive(k, 1'b1, 3'($urandom_range(0, 7)), pick(), pick());
                else
                    drive(k, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
            end
            @(posedge clk);
            #1;
        end
        drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (40) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
